// File: rtl/ntt_layer_scheduler_pkg.sv
// Shared types and constants for the Kyber NTT layer scheduler.
//   state_e : scheduler FSM states
//   mode_e  : butterfly operand-pairing modes sent to the datapath
//   N_COEF, N_BU, ISSUE_PER_LAYER : transform geometry
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Cross-word pairs two different words (len >= 8). LEN4/LEN2 pair
  // coefficients inside one word, on the two ports of consecutive words.
  typedef enum logic [1:0] {
    MODE_CROSS = 2'd0,
    MODE_LEN4  = 2'd1,
    MODE_LEN2  = 2'd2
  } mode_e;

  localparam int N_COEF          = 256;
  localparam int N_BU            = 8;
  // Each issue feeds all N_BU butterflies with two coefficients apiece.
  localparam int ISSUE_PER_LAYER = N_COEF / (2 * N_BU);

endpackage

// File: rtl/ntt_layer_scheduler_if.sv
// Memory/datapath-side bus of the NTT layer scheduler.
//   rd_en_o, rd_addr_a_o, rd_addr_b_o, rd_mode_o, tw_base_o : read issue
//   wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_mode_o            : write-back
// master: the scheduler drives everything; slave: banks/butterflies observe.
interface ntt_layer_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int TW_WIDTH   = 7
);

  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_a_o;
  logic [ADDR_WIDTH-1:0] rd_addr_b_o;
  logic [1:0]            rd_mode_o;
  logic [TW_WIDTH-1:0]   tw_base_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_a_o;
  logic [ADDR_WIDTH-1:0] wr_addr_b_o;
  logic [1:0]            wr_mode_o;

  modport master (
    output rd_en_o, rd_addr_a_o, rd_addr_b_o, rd_mode_o, tw_base_o,
    output wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_mode_o
  );

  modport slave (
    input rd_en_o, rd_addr_a_o, rd_addr_b_o, rd_mode_o, tw_base_o,
    input wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_mode_o
  );

endinterface

// File: rtl/ntt_layer_scheduler_addr_delay.sv
// Latency-matched delay line that turns read issues into write-backs.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   in_valid/in_addr_*/in_mode    : read issue entering the pipe
//   out_valid/out_addr_*/out_mode : same issue DEPTH cycles later (zero when invalid)
module ntt_addr_delay #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr_a,
  input  logic [ADDR_WIDTH-1:0] in_addr_b,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr_a,
  output logic [ADDR_WIDTH-1:0] out_addr_b,
  output logic [1:0]            out_mode
);

  localparam int PW = 2 * ADDR_WIDTH + 2;

  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    payload_q [DEPTH];

  // Valid bits are cleared by reset so an aborted run issues no late writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: the payload array is deliberately not reset; only the valid bits
  // need a known value, and the output gating below hides stale payload.
  always_ff @(posedge clk_i) begin
    payload_q[0] <= {in_addr_a, in_addr_b, in_mode};
    for (int i = 1; i < DEPTH; i++) payload_q[i] <= payload_q[i-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign {out_addr_a, out_addr_b, out_mode} = out_valid ? payload_q[DEPTH-1] : '0;

endmodule

// File: rtl/ntt_layer_scheduler.sv
// Issues the read/twiddle/write-back schedule for all layers of a 256-point
// Kyber NTT or INTT over 8 butterflies and 8 banks (coefficient i lives in
// bank i[2:0], word i[7:3]).
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : start pulse, accepted only in IDLE
//   is_ntt_i     : 1 = forward NTT, 0 = INTT, sampled with start_i
//   busy_o       : high from the cycle after start through the done_o cycle
//   done_o       : one-cycle completion pulse
//   is_ntt_o     : latched direction
//   layer_o      : layer index l currently being issued (0 when idle)
//   bus          : read issue / write-back bus (master side)
module ntt_layer_scheduler
  import ntt_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int TW_WIDTH   = 7,
  parameter int RD_LATE    = 1,
  parameter int BU_LATE    = 7,
  parameter int NUM_LAYERS = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        is_ntt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        is_ntt_o,
  output logic [2:0]  layer_o,
  ntt_layer_scheduler_if.master bus
);

  localparam int D   = RD_LATE + BU_LATE;
  localparam int DW  = $clog2(D + 1);
  localparam int TWX = TW_WIDTH + 1;

  localparam logic [2:0]    LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam logic [3:0]    ISSUE_LAST = 4'(ISSUE_PER_LAYER - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(D - 1);
  // Layers up to this index pair coefficients held in different words.
  localparam logic [2:0]    CROSS_LAST = 3'd4;

  state_e          state_q, state_d;
  logic [2:0]      layer_cnt_q;
  logic [3:0]      k_q;
  logic [DW-1:0]   drain_q;
  logic            is_ntt_q;

  logic [2:0]            l;
  logic [2:0]            s;
  logic [ADDR_WIDTH-1:0] kx;
  logic [TW_WIDTH-1:0]   kt;
  logic [TW_WIDTH-1:0]   g;
  logic [TWX-1:0]        tw_ext;

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_a, rd_b;
  mode_e                 rd_mode;
  logic [TW_WIDTH-1:0]   tw;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_a, wr_b;
  logic [1:0]            wr_mode;

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE;
      ISSUE:   if (k_q == ISSUE_LAST) state_d = DRAIN;
      DRAIN:   if (drain_q == DRAIN_LAST)
                 state_d = (layer_cnt_q == LAST_LAYER) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      layer_cnt_q <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      is_ntt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          is_ntt_q    <= is_ntt_i;
          layer_cnt_q <= '0;
          k_q         <= '0;
          drain_q     <= '0;
        end
        ISSUE: begin
          k_q     <= k_q + 4'd1;  // wraps 15 -> 0 ready for the next layer
          drain_q <= '0;
        end
        DRAIN: begin
          drain_q <= drain_q + DW'(1);
          if (drain_q == DRAIN_LAST && layer_cnt_q != LAST_LAYER)
            layer_cnt_q <= layer_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // INTT walks the layers backwards, so len=2 comes first.
  assign l  = is_ntt_q ? layer_cnt_q : LAST_LAYER - layer_cnt_q;
  assign kx = ADDR_WIDTH'(k_q);
  assign kt = TW_WIDTH'(k_q);

  // NOTE: every output and temporary gets a default before the case logic,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    busy_o   = (state_q != IDLE);
    done_o   = (state_q == DONE);
    is_ntt_o = is_ntt_q;
    layer_o  = busy_o ? l : 3'd0;
    rd_en    = 1'b0;
    rd_a     = '0;
    rd_b     = '0;
    rd_mode  = MODE_CROSS;
    tw       = '0;
    s        = '0;
    g        = '0;
    tw_ext   = '0;
    if (state_q == ISSUE) begin
      rd_en = 1'b1;
      if (l <= CROSS_LAST) begin
        // Insert a zero at bit s of k: the low s bits select the word within
        // a half-group, the upper bits pick the group of 2*len_w words.
        s    = CROSS_LAST - l;
        rd_a = ((kx >> s) << (s + 3'd1)) | (kx & ((ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1)));
        rd_b = rd_a + (ADDR_WIDTH'(1) << s);
        g    = kt >> s;
      end else if (l == CROSS_LAST + 3'd1) begin
        rd_a    = kx << 1;
        rd_b    = rd_a | ADDR_WIDTH'(1);
        rd_mode = MODE_LEN4;
        g       = kt << 1;
      end else begin
        rd_a    = kx << 1;
        rd_b    = rd_a | ADDR_WIDTH'(1);
        rd_mode = MODE_LEN2;
        g       = kt << 2;
      end
      // One spare bit keeps 2^(l+1)-1 exact at l=6 before truncation.
      if (is_ntt_q) tw_ext = (TWX'(1) << l) + TWX'(g);
      else          tw_ext = ((TWX'(1) << (l + 3'd1)) - TWX'(1)) - TWX'(g);
      tw = tw_ext[TW_WIDTH-1:0];
    end
  end

  ntt_addr_delay #(
    .DEPTH      (D),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_delay (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid   (rd_en),
    .in_addr_a  (rd_a),
    .in_addr_b  (rd_b),
    .in_mode    (rd_mode),
    .out_valid  (wr_en),
    .out_addr_a (wr_a),
    .out_addr_b (wr_b),
    .out_mode   (wr_mode)
  );

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_a_o = rd_a;
  assign bus.rd_addr_b_o = rd_b;
  assign bus.rd_mode_o   = rd_mode;
  assign bus.tw_base_o   = tw;
  assign bus.wr_en_o     = wr_en;
  assign bus.wr_addr_a_o = wr_a;
  assign bus.wr_addr_b_o = wr_b;
  assign bus.wr_mode_o   = wr_mode;

endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// Self-checking bench for ntt_layer_scheduler: reset state, table vectors
// from hand-computed addresses/twiddles, full NTT/INTT runs against a
// cycle-indexed reference model, random start noise while busy, and an
// abort by reset mid-run.
module tb_ntt_layer_scheduler;

  localparam int D      = 8;
  localparam int PERIOD = 16 + D;
  localparam int DONE_C = 1 + 7 * PERIOD;   // 169
  localparam int RUN_C  = DONE_C + 6;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       is_ntt_i = 1'b0;
  logic       busy_o, done_o, is_ntt_o;
  logic [2:0] layer_o;

  ntt_layer_scheduler_if #(.ADDR_WIDTH(5), .TW_WIDTH(7)) bus ();

  ntt_layer_scheduler dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .is_ntt_i (is_ntt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .is_ntt_o (is_ntt_o),
    .layer_o  (layer_o),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  // Read records captured per direction and cycle: {en, a, b, mode, tw}.
  logic [19:0] cap [2][RUN_C+1];

  typedef struct {
    bit          ntt;
    int          l;
    int          k;
    logic [19:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, busy_o, done_o, is_ntt_o, layer_o,
            bus.rd_en_o, bus.rd_addr_a_o, bus.rd_addr_b_o, bus.rd_mode_o, bus.tw_base_o,
            bus.wr_en_o, bus.wr_addr_a_o, bus.wr_addr_b_o, bus.wr_mode_o};
  endfunction

  function automatic logic [19:0] pack_rd(int a, int b, int mode, int tw);
    logic [4:0] a5, b5;
    logic [1:0] m2;
    logic [6:0] t7;
    a5 = a[4:0]; b5 = b[4:0]; m2 = mode[1:0]; t7 = tw[6:0];
    return {1'b1, a5, b5, m2, t7};
  endfunction

  // Reference: which butterfly pairs and twiddle each issue slot carries,
  // derived from len = 128 >> l with plain division.
  function automatic logic [19:0] model_rd(bit ntt, int c);
    int j, k, l, len, lw, a, b, g, mode, tw;
    if (c < 1 || c > DONE_C - 1) return '0;
    j = (c - 1) / PERIOD;
    k = (c - 1) % PERIOD;
    if (k >= 16 || j > 6) return '0;
    l   = ntt ? j : 6 - j;
    len = 128 >> l;
    if (len >= 8) begin
      lw   = len / 8;
      a    = (k / lw) * 2 * lw + (k % lw);
      b    = a + lw;
      g    = k / lw;
      mode = 0;
    end else begin
      a    = 2 * k;
      b    = a + 1;
      g    = (len == 4) ? 2 * k : 4 * k;
      mode = (len == 4) ? 1 : 2;
    end
    tw = ntt ? (2 ** l) + g : (2 ** (l + 1) - 1) - g;
    return pack_rd(a, b, mode, tw);
  endfunction

  function automatic logic [12:0] model_wr(bit ntt, int c);
    logic [19:0] r;
    r = model_rd(ntt, c - D);
    return r[19:7];
  endfunction

  function automatic logic [5:0] model_ctrl(bit ntt, int c);
    int j, l;
    logic [2:0] l3;
    if (c < 1 || c > DONE_C) return {1'b0, 1'b0, ntt, 3'd0};
    j  = (c - 1) / PERIOD;
    if (j > 6) j = 6;
    l  = ntt ? j : 6 - j;
    l3 = l[2:0];
    return {1'b1, (c == DONE_C), ntt, l3};
  endfunction

  // One full transform; optional random start pulses (and direction noise)
  // while busy, always including one on the done_o cycle.
  task automatic run_xform(input bit ntt, input bit inject);
    int rd_seen, wr_seen;
    logic [19:0] rd_obs;
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk_i);
    start_i  = 1'b1;
    is_ntt_i = ntt;
    for (int c = 1; c <= RUN_C; c++) begin
      @(negedge clk_i);
      rd_obs = {bus.rd_en_o, bus.rd_addr_a_o, bus.rd_addr_b_o, bus.rd_mode_o, bus.tw_base_o};
      cap[ntt][c] = rd_obs;
      check($sformatf("rd c=%0d", c), 64'(rd_obs), 64'(model_rd(ntt, c)));
      check($sformatf("wr c=%0d", c),
            64'({bus.wr_en_o, bus.wr_addr_a_o, bus.wr_addr_b_o, bus.wr_mode_o}),
            64'(model_wr(ntt, c)));
      check($sformatf("ctrl c=%0d", c), 64'({busy_o, done_o, is_ntt_o, layer_o}),
            64'(model_ctrl(ntt, c)));
      if (bus.rd_en_o) begin
        if (rd_seen % 16 == 0)
          check($sformatf("raw_hazard c=%0d", c), 64'(wr_seen), 64'(rd_seen));
        rd_seen++;
      end
      if (bus.wr_en_o) wr_seen++;
      if (inject && c <= DONE_C) begin
        start_i  = (c == DONE_C) || ($urandom_range(0, 3) == 0);
        is_ntt_i = 1'($urandom_range(0, 1));
      end else begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check("rd_en_count", 64'(rd_seen), 64'd112);
    check("wr_en_count", 64'(wr_seen), 64'd112);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 0, 0, pack_rd(0, 16, 0, 1)};
    vecs[1] = '{1'b1, 0, 5, pack_rd(5, 21, 0, 1)};
    vecs[2] = '{1'b1, 3, 5, pack_rd(9, 11, 0, 10)};
    vecs[3] = '{1'b1, 5, 3, pack_rd(6, 7, 1, 38)};
    vecs[4] = '{1'b1, 6, 2, pack_rd(4, 5, 2, 72)};
    vecs[5] = '{1'b0, 6, 0, pack_rd(0, 1, 2, 127)};
    vecs[6] = '{1'b0, 6, 1, pack_rd(2, 3, 2, 123)};
    vecs[7] = '{1'b0, 0, 0, pack_rd(0, 16, 0, 1)};

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_state", all_outs(), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_after_reset", all_outs(), 64'd0);

    // Clean NTT then INTT runs, then the table vectors against their captures.
    run_xform(1'b1, 1'b0);
    run_xform(1'b0, 1'b0);
    foreach (vecs[i]) begin
      int j, c;
      j = vecs[i].ntt ? vecs[i].l : 6 - vecs[i].l;
      c = 1 + PERIOD * j + vecs[i].k;
      check($sformatf("vec%0d ntt=%0d l=%0d k=%0d", i, vecs[i].ntt, vecs[i].l, vecs[i].k),
            64'(cap[vecs[i].ntt][c]), 64'(vecs[i].exp));
    end

    // Random direction, random idle gaps, start noise while busy.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_i);
      run_xform(1'($urandom_range(0, 1)), 1'b1);
    end

    // Abort by reset in the middle of layer 2 with writes still in flight.
    @(negedge clk_i);
    start_i  = 1'b1;
    is_ntt_i = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check("busy_before_abort", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("reset_abort", all_outs(), 64'd0);
    rst_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      check($sformatf("post_abort c=%0d", c), all_outs(), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ntt_layer_scheduler.md
Name: ntt_layer_scheduler

Overview:
Sequences all 7 layers of a 256-point Kyber NTT/INTT (q=3329, 12-bit coefficients) over 8 butterfly units and 8 dual-port coefficient BRAMs of 32 words each.
Each cycle it issues one read-address pair, the mode and the twiddle base. Through a latency-matched delay line it issues the matching write-back address pair.
It runs after the load phase and before the output phase. Between layers it stalls issue until all write-backs complete, which closes the read-after-write hazard.

Parameters:
ADDR_WIDTH, 5, BRAM word address width (32 words/bank)
TW_WIDTH, 7, twiddle (zeta) index width
RD_LATE, 1, BRAM read latency in cycles
BU_LATE, 7, butterfly pipeline latency in cycles
NUM_LAYERS, 7, layers per transform

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start pulse; ignored while busy_o=1
is_ntt_i  in  1  1=forward NTT, 0=INTT; sampled with start_i
busy_o  out  1  high from the cycle after start is accepted through the done_o cycle
done_o  out  1  one-cycle pulse at completion
is_ntt_o  out  1  latched direction
layer_o  out  3  current issue layer index l (0..6)
rd_en_o  out  1  read issue valid
rd_addr_a_o  out  ADDR_WIDTH  port-A word address, common to all banks
rd_addr_b_o  out  ADDR_WIDTH  port-B word address
rd_mode_o  out  2  0=cross-word (len>=8), 1=len4, 2=len2
tw_base_o  out  TW_WIDTH  twiddle index for BU0
wr_en_o  out  1  write-back valid (drives all 8 bank WEs)
wr_addr_a_o  out  ADDR_WIDTH  delayed rd_addr_a_o
wr_addr_b_o  out  ADDR_WIDTH  delayed rd_addr_b_o
wr_mode_o  out  2  delayed rd_mode_o

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, delay-line valid bits cleared. Reset mid-run aborts immediately; no write is issued after reset.
- Storage map: coefficient i lives in bank i[2:0], word i[7:3].
- States:
  - IDLE: on start_i, latch is_ntt_i, set layer/issue counters to 0, go to ISSUE.
  - ISSUE: 16 cycles, k=0..15, rd_en_o=1. After k=15 go to DRAIN.
  - DRAIN: D=RD_LATE+BU_LATE cycles with rd_en_o=0. Exit to ISSUE for the next layer, or to DONE after the last layer.
  - DONE: one cycle, done_o=1, then IDLE.
- Layer order: NTT uses l=0..6 with len=128>>l. INTT uses l=6..0, i.e. len=2 first.
- Cross-word mode (l<=4):
  - len_w=len>>3, s=log2(len_w).
  - rd_addr_a = {k[3:s], 1'b0, k[s-1:0]} (bit insertion), rd_addr_b = rd_addr_a + len_w.
  - Group g = k>>s.
- l=5 (len 4): addr_a=2k, addr_b=2k+1, mode=1, g=2k.
- l=6 (len 2): addr_a=2k, addr_b=2k+1, mode=2, g=4k.
- Twiddle base:
  - NTT: tw_base = 2^l + g.
  - INTT: tw_base = (2^(l+1)-1) - g.
  - Per-BU expansion (ascending for NTT, descending for INTT) is done downstream.
- Write path: wr_* equals rd_* delayed exactly D cycles. wr_en_o is high for exactly 16 cycles per layer.
- Timing (D=8): start sampled at cycle 0; first rd_en_o at cycle 1; layer period 16+D=24 cycles.
  - NTT layer 0: reads on cycles 1..16, writes on cycles 9..24; layer 1 reads begin cycle 25.
  - Last write lands on cycle 168; done_o pulses on cycle 169; busy_o drops on cycle 170.
- start_i while busy: ignored. start_i on the done_o cycle: ignored. Accepted only in IDLE.
- Counter wrap: issue counter wraps 15->0 with no overflow flag. Layer counter never exceeds 6.

Decomposition:
- Package ntt_pkg holds: state enum (IDLE, ISSUE, DRAIN, DONE); mode encodings (MODE_CROSS, MODE_LEN4, MODE_LEN2); constants N_COEF=256, N_BU=8, ISSUE_PER_LAYER=16.
- Sub-module ntt_addr_delay: parameterised DEPTH=D shift register carrying {valid, addr_a, addr_b, mode}, with valid cleared on reset.

Test Plan:
- NTT, layer 0, k=0 and k=5 -> addr (0,16) with tw 1; addr (5,21) with tw 1; mode 0.
- NTT, layer 3, k=5 -> addr_a 9, addr_b 11, tw_base 10, mode 0.
- NTT, layer 5, k=3 -> addr (6,7), mode 1, tw_base 38. Layer 6, k=2 -> addr (4,5), mode 2, tw_base 72.
- INTT start -> first issue is layer 6: k=0 gives tw 127, k=1 gives tw 123. Last layer (l=0) k=0 gives addr (0,16), tw 1.
- Full NTT run with D=8 -> 112 rd_en_o cycles and 112 wr_en_o cycles. Each wr pair equals its rd pair delayed 8 cycles. done_o on cycle 169. No read of a layer precedes the last write of the previous layer.
- Assert rst_i at cycle 50 -> next cycle all outputs 0, no further wr_en_o. A start_i pulse while busy -> no effect on timing.
